// File: rtl/hazard_ctrl.sv
// Load-use / memory-wait hazard controller: Mealy stall, bubble, freeze and flush controls.
// Zero-cycle response to hazard, branch and busy inputs; debug stall counter and sticky timeout flag.
module hazard_ctrl #(
   parameter int PARAM_LOAD_LAT    = 1,
   parameter int PARAM_MEM_TIMEOUT = 15,
   parameter int PARAM_CNT_WIDTH   = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       ip_idex_mem_read,
   input  logic [4:0]                 ip_idex_rt,
   input  logic [4:0]                 ip_ifid_rs,
   input  logic [4:0]                 ip_ifid_rt,
   input  logic                       ip_ifid_uses_rt,
   input  logic                       ip_branch_taken,
   input  logic                       ip_dmem_busy,
   output logic                       op_stall,
   output logic                       op_bubble,
   output logic                       op_freeze,
   output logic                       op_flush,
   output logic [1:0]                 op_state,
   output logic [PARAM_CNT_WIDTH-1:0] op_stall_count,
   output logic                       op_error
);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      MEM_WAIT   = 2'b10,
      ILLEGAL    = 2'b11
   } state_t;

   localparam logic [2:0] LAT_INIT = 3'(PARAM_LOAD_LAT - 1);
   localparam logic [7:0] TIMEOUT  = 8'(PARAM_MEM_TIMEOUT);

   state_t     state, state_nxt;
   logic [2:0] lat_cnt, lat_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       err_set;
   logic       run_like;
   logic       haz;
   logic       stall_c, bubble_c, freeze_c, flush_c;

   assign haz = ip_idex_mem_read && (ip_idex_rt != 5'd0) &&
                ((ip_idex_rt == ip_ifid_rs) || (ip_ifid_uses_rt && (ip_idex_rt == ip_ifid_rt)));

   always_comb begin
      state_nxt = state;
      lat_nxt   = lat_cnt;
      wait_nxt  = wait_cnt;
      err_set   = 1'b0;
      run_like  = 1'b0;
      stall_c   = 1'b0;
      bubble_c  = 1'b0;
      freeze_c  = 1'b0;
      flush_c   = 1'b0;

      case (state)
         RUN: run_like = 1'b1;
         LOAD_STALL: begin
            if (ip_branch_taken) begin
               flush_c   = 1'b1;
               state_nxt = RUN;
            end else if (ip_dmem_busy) begin
               stall_c   = 1'b1;
               freeze_c  = 1'b1;
               wait_nxt  = 8'd1;
               state_nxt = MEM_WAIT;
            end else begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
               lat_nxt  = lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  state_nxt = RUN;
               end
            end
         end
         MEM_WAIT: begin
            // Execute is frozen while busy, so a branch outcome here is stale.
            if (ip_dmem_busy) begin
               stall_c  = 1'b1;
               freeze_c = 1'b1;
               if (wait_cnt == TIMEOUT) begin
                  err_set   = 1'b1;
                  state_nxt = RUN;
               end else begin
                  wait_nxt = wait_cnt + 8'd1;
               end
            end else begin
               run_like = 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase

      // The cycle memory releases behaves exactly like RUN.
      if (run_like) begin
         state_nxt = RUN;
         if (ip_branch_taken) begin
            flush_c = 1'b1;
         end else if (ip_dmem_busy) begin
            stall_c   = 1'b1;
            freeze_c  = 1'b1;
            wait_nxt  = 8'd1;
            state_nxt = MEM_WAIT;
         end else if (haz) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (PARAM_LOAD_LAT > 1) begin
               lat_nxt   = LAT_INIT;
               state_nxt = LOAD_STALL;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         lat_cnt  <= 3'd0;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         lat_cnt  <= lat_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_stall_count <= '0;
         op_error       <= 1'b0;
      end else begin
         if (op_stall && (op_stall_count != {PARAM_CNT_WIDTH{1'b1}})) begin
            op_stall_count <= op_stall_count + PARAM_CNT_WIDTH'(1);
         end
         if (err_set) begin
            op_error <= 1'b1;
         end
      end
   end

   // Reset gates the Mealy outputs so inputs cannot leak through while held.
   assign op_stall  = reset & stall_c;
   assign op_bubble = reset & bubble_c;
   assign op_freeze = reset & freeze_c;
   assign op_flush  = reset & flush_c;
   assign op_state  = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations driven by shared stimulus, directed scenarios plus randomized model check.
module tb_hazard_ctrl;

   localparam int LAT_A = 1, TO_A = 15, CW_A = 16;
   localparam int LAT_B = 3, TO_B = 15, CW_B = 4;
   localparam int LAT_C = 2, TO_C = 3,  CW_C = 8;

   int p_lat [3] = '{LAT_A, LAT_B, LAT_C};
   int p_to  [3] = '{TO_A, TO_B, TO_C};
   int p_cw  [3] = '{CW_A, CW_B, CW_C};

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       mr, urt, br, busy;
   logic [4:0] irt, rs, rt;

   logic [2:0]      stall, bubble, freeze, flush, err;
   logic [2:0][1:0] st;
   logic [15:0]     cnt0;
   logic [3:0]      cnt1;
   logic [7:0]      cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: mode 0 run, 1 load stall, 2 memory wait
   int   m_mode [3], m_left [3], m_waited [3], m_err [3], m_cnt [3];
   int   n_mode [3], n_left [3], n_waited [3], n_err [3], n_cnt [3];
   logic [3:0] e_ctl [3];

   hazard_ctrl #(.PARAM_LOAD_LAT(LAT_A), .PARAM_MEM_TIMEOUT(TO_A), .PARAM_CNT_WIDTH(CW_A)) dut_a (
      .clock(clock), .reset(reset), .ip_idex_mem_read(mr), .ip_idex_rt(irt), .ip_ifid_rs(rs),
      .ip_ifid_rt(rt), .ip_ifid_uses_rt(urt), .ip_branch_taken(br), .ip_dmem_busy(busy),
      .op_stall(stall[0]), .op_bubble(bubble[0]), .op_freeze(freeze[0]), .op_flush(flush[0]),
      .op_state(st[0]), .op_stall_count(cnt0), .op_error(err[0]));

   hazard_ctrl #(.PARAM_LOAD_LAT(LAT_B), .PARAM_MEM_TIMEOUT(TO_B), .PARAM_CNT_WIDTH(CW_B)) dut_b (
      .clock(clock), .reset(reset), .ip_idex_mem_read(mr), .ip_idex_rt(irt), .ip_ifid_rs(rs),
      .ip_ifid_rt(rt), .ip_ifid_uses_rt(urt), .ip_branch_taken(br), .ip_dmem_busy(busy),
      .op_stall(stall[1]), .op_bubble(bubble[1]), .op_freeze(freeze[1]), .op_flush(flush[1]),
      .op_state(st[1]), .op_stall_count(cnt1), .op_error(err[1]));

   hazard_ctrl #(.PARAM_LOAD_LAT(LAT_C), .PARAM_MEM_TIMEOUT(TO_C), .PARAM_CNT_WIDTH(CW_C)) dut_c (
      .clock(clock), .reset(reset), .ip_idex_mem_read(mr), .ip_idex_rt(irt), .ip_ifid_rs(rs),
      .ip_ifid_rt(rt), .ip_ifid_uses_rt(urt), .ip_branch_taken(br), .ip_dmem_busy(busy),
      .op_stall(stall[2]), .op_bubble(bubble[2]), .op_freeze(freeze[2]), .op_flush(flush[2]),
      .op_state(st[2]), .op_stall_count(cnt2), .op_error(err[2]));

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog time limit expired");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] get_cnt(input int k);
      if (k == 0) return cnt0;
      if (k == 1) return {12'd0, cnt1};
      return {8'd0, cnt2};
   endfunction

   function automatic logic [3:0] ctl(input int k);
      return {stall[k], bubble[k], freeze[k], flush[k]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_mode[k] = 0; m_left[k] = 0; m_waited[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic model_eval();
      for (int k = 0; k < 3; k++) begin
         logic h, s, bb, fz, fl;
         h  = mr && (irt != 5'd0) && ((irt == rs) || (urt && (irt == rt)));
         s  = 1'b0; bb = 1'b0; fz = 1'b0; fl = 1'b0;
         n_mode[k] = 0; n_left[k] = m_left[k]; n_waited[k] = m_waited[k]; n_err[k] = m_err[k];
         if (!reset) begin
            n_left[k] = 0;
         end else if (m_mode[k] == 1 && !br && !busy) begin
            s = 1'b1; bb = 1'b1;
            n_left[k] = m_left[k] - 1;
            n_mode[k] = (n_left[k] == 0) ? 0 : 1;
         end else if (m_mode[k] == 2 && busy) begin
            s = 1'b1; fz = 1'b1;
            if (m_waited[k] >= p_to[k]) begin
               n_err[k] = 1;
            end else begin
               n_waited[k] = m_waited[k] + 1;
               n_mode[k]   = 2;
            end
         end else if (br) begin
            fl = 1'b1;
         end else if (busy) begin
            s = 1'b1; fz = 1'b1;
            n_waited[k] = 1;
            n_mode[k]   = 2;
         end else if (h) begin
            s = 1'b1; bb = 1'b1;
            n_left[k] = p_lat[k] - 1;
            n_mode[k] = (n_left[k] > 0) ? 1 : 0;
         end
         e_ctl[k] = {s, bb, fz, fl};
         n_cnt[k] = (s && m_cnt[k] < (2 ** p_cw[k]) - 1) ? m_cnt[k] + 1 : m_cnt[k];
      end
   endtask

   task automatic apply(input logic a_mr, input logic [4:0] a_irt, input logic [4:0] a_rs,
                        input logic [4:0] a_rt, input logic a_urt, input logic a_br, input logic a_busy);
      mr = a_mr; irt = a_irt; rs = a_rs; rt = a_rt; urt = a_urt; br = a_br; busy = a_busy;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            m_mode[k] = n_mode[k]; m_left[k] = n_left[k]; m_waited[k] = n_waited[k];
            m_err[k] = n_err[k]; m_cnt[k] = n_cnt[k];
         end
      end
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      mr = 1'b0; irt = 5'd0; rs = 5'd0; rt = 5'd0; urt = 1'b0; br = 1'b0; busy = 1'b0;
      #1;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      mr = 1'b1; irt = 5'd2; rs = 5'd2; rt = 5'd0; urt = 1'b0; br = 1'b0; busy = 1'b1;
      model_reset();
      #2;
      n_tests++;
      if (ctl(0) !== 4'b0000 || ctl(1) !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctl got a=%b b=%b want 0000", ctl(0), ctl(1));
      end
      @(posedge clock); #1;
      n_tests++;
      if (st[0] !== 2'b00 || cnt0 !== 16'd0 || err[0] !== 1'b0 || ctl(0) !== 4'b0000) begin
         n_fail++; $display("FAIL reset_state got st=%b cnt=%0d err=%b ctl=%b want 00 0 0 0000", st[0], cnt0, err[0], ctl(0));
      end
      @(negedge clock);
      do_reset();
   endtask

   task automatic test_load_rs();
      do_reset();
      apply(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (ctl(0) !== 4'b1100) begin
         n_fail++; $display("FAIL load_rs_ctl got %b want 1100", ctl(0));
      end
      tick();
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (ctl(0) !== 4'b0000 || st[0] !== 2'b00) begin
         n_fail++; $display("FAIL load_rs_after got ctl=%b st=%b want 0000 00", ctl(0), st[0]);
      end
      n_tests++;
      if (cnt0 !== 16'd1) begin
         n_fail++; $display("FAIL load_rs_count got %0d want 1", cnt0);
      end
      tick();
      idle(3);
      apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (stall[0] !== 1'b0 || stall[1] !== 1'b0) begin
         n_fail++; $display("FAIL load_rs_zero got a=%b b=%b want 0 0", stall[0], stall[1]);
      end
      tick();
   endtask

   task automatic test_load_rt();
      logic [1:0] est [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
      logic [3:0] ectl [4] = '{4'b1100, 4'b1100, 4'b1100, 4'b0000};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) apply(1'b1, 5'd3, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0);
         else        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         n_tests++;
         if (st[1] !== est[i] || ctl(1) !== ectl[i]) begin
            n_fail++; $display("FAIL load_rt_cyc%0d got st=%b ctl=%b want %b %b", i, st[1], ctl(1), est[i], ectl[i]);
         end
         tick();
      end
      apply(1'b1, 5'd3, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (cnt1 !== 4'd3 || stall[1] !== 1'b0) begin
         n_fail++; $display("FAIL load_rt_norf got cnt=%0d stall=%b want 3 0", cnt1, stall[1]);
      end
      tick();
   endtask

   task automatic test_branch_abort();
      do_reset();
      apply(1'b1, 5'd3, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (st[1] !== 2'b01 || stall[1] !== 1'b1) begin
         n_fail++; $display("FAIL abort_pre got st=%b stall=%b want 01 1", st[1], stall[1]);
      end
      tick();
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (ctl(1) !== 4'b0001) begin
         n_fail++; $display("FAIL abort_flush got %b want 0001", ctl(1));
      end
      tick();
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (st[1] !== 2'b00 || ctl(1) !== 4'b0000) begin
         n_fail++; $display("FAIL abort_post got st=%b ctl=%b want 00 0000", st[1], ctl(1));
      end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i == 2), 1'b1);
         n_tests++;
         if (ctl(0) !== 4'b1010 || st[0] !== ((i == 0) ? 2'b00 : 2'b10)) begin
            n_fail++; $display("FAIL memwait_cyc%0d got ctl=%b st=%b want 1010 %b", i, ctl(0), st[0], (i == 0) ? 2'b00 : 2'b10);
         end
         tick();
      end
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (ctl(0) !== 4'b0000 || st[0] !== 2'b10) begin
         n_fail++; $display("FAIL memwait_release got ctl=%b st=%b want 0000 10", ctl(0), st[0]);
      end
      tick();
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (st[0] !== 2'b00 || cnt0 !== 16'd4 || err[0] !== 1'b0) begin
         n_fail++; $display("FAIL memwait_end got st=%b cnt=%0d err=%b want 00 4 0", st[0], cnt0, err[0]);
      end
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
         n_tests++;
         if (err[0] !== (i >= 16) || ctl(0) !== 4'b1010) begin
            n_fail++; $display("FAIL timeout_cyc%0d got err=%b ctl=%b want %b 1010", i, err[0], ctl(0), (i >= 16));
         end
         if (i == 16) begin
            n_tests++;
            if (st[0] !== 2'b00) begin
               n_fail++; $display("FAIL timeout_run got st=%b want 00", st[0]);
            end
         end
         tick();
      end
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (cnt0 !== 16'd20 || cnt1 !== 4'd15) begin
         n_fail++; $display("FAIL count_sat got a=%0d b=%0d want 20 15", cnt0, cnt1);
      end
      tick();
      idle(3);
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (err[0] !== 1'b1 || err[1] !== 1'b1) begin
         n_fail++; $display("FAIL error_sticky got a=%b b=%b want 1 1", err[0], err[1]);
      end
      do_reset();
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (err[0] !== 1'b0) begin
         n_fail++; $display("FAIL error_clear got %b want 0", err[0]);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      repeat (2) begin
         apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
         tick();
      end
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (st[0] !== 2'b10 || stall[0] !== 1'b1) begin
         n_fail++; $display("FAIL midrst_pre got st=%b stall=%b want 10 1", st[0], stall[0]);
      end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (ctl(0) !== 4'b0000 || ctl(1) !== 4'b0000 || st[0] !== 2'b00 || cnt0 !== 16'd0) begin
         n_fail++; $display("FAIL midrst_async got ctl=%b/%b st=%b cnt=%0d want 0000 00 0", ctl(0), ctl(1), st[0], cnt0);
      end
      @(negedge clock);
      reset = 1'b1;
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (st[0] !== 2'b00 || stall[0] !== 1'b0 || cnt0 !== 16'd0) begin
         n_fail++; $display("FAIL midrst_post got st=%b stall=%b cnt=%0d want 00 0 0", st[0], stall[0], cnt0);
      end
      tick();
   endtask

   task automatic test_random();
      logic b_busy;
      b_busy = 1'b0;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (b_busy) b_busy = ($urandom_range(0, 99) < 85);
         else        b_busy = ($urandom_range(0, 99) < 12);
         apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 10), b_busy);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ctl(k) !== e_ctl[k] || st[k] !== 2'(m_mode[k]) || err[k] !== 1'(m_err[k]) ||
                get_cnt(k) !== 16'(m_cnt[k])) begin
               n_fail++;
               $display("FAIL random_dut%0d_cyc%0d got ctl=%b st=%b err=%b cnt=%0d want %b %0d %0d %0d",
                        k, i, ctl(k), st[k], err[k], get_cnt(k), e_ctl[k], m_mode[k], m_err[k], m_cnt[k]);
            end
            n_tests++;
            if ((stall[k] & flush[k]) !== 1'b0) begin
               n_fail++; $display("FAIL random_excl_dut%0d_cyc%0d got stall&flush=%b want 0", k, i, stall[k] & flush[k]);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_rs();
      test_load_rt();
      test_branch_abort();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It detects load-use hazards between the IF/ID and ID/EX registers and sequences multi-cycle data-memory waits. From these it generates the stall, bubble, freeze and flush controls consumed by the fetch stage and the downstream pipeline registers. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error flag for debug.

## Interface
Parameters:
- PARAM_LOAD_LAT, 1: bubble cycles inserted per load-use hazard, 1..7.
- PARAM_MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before an error, 1..255.
- PARAM_CNT_WIDTH, 16: width of the stall-cycle counter.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ip_idex_mem_read  input  1  ID/EX holds a load (lw).
- ip_idex_rt  input  5  destination register of the ID/EX load.
- ip_ifid_rs  input  5  rs field of the IF/ID instruction.
- ip_ifid_rt  input  5  rt field of the IF/ID instruction.
- ip_ifid_uses_rt  input  1  IF/ID instruction reads rt (R-type, beq, sw).
- ip_branch_taken  input  1  execute-stage branch AND zero.
- ip_dmem_busy  input  1  data memory not ready this cycle.
- op_stall  output  1  hold PC and IF/ID.
- op_bubble  output  1  load a NOP into ID/EX.
- op_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- op_flush  output  1  squash IF/ID (taken branch).
- op_state  output  2  current FSM state encoding.
- op_stall_count  output  PARAM_CNT_WIDTH  saturating count of cycles with op_stall=1.
- op_error  output  1  sticky memory-timeout flag.

## Operation
- Hazard term: haz = ip_idex_mem_read && ip_idex_rt != 0 && (ip_idex_rt == ip_ifid_rs || (ip_ifid_uses_rt && ip_idex_rt == ip_ifid_rt)).
- FSM states: RUN=2'b00, LOAD_STALL=2'b01, MEM_WAIT=2'b10. Encoding 2'b11 is illegal and returns to RUN on the next edge with all outputs 0.
- Priority in RUN and LOAD_STALL: ip_branch_taken > ip_dmem_busy > haz.
- RUN:
  - branch_taken: op_flush=1, all other controls 0, stay in RUN.
  - dmem_busy: op_stall=op_freeze=1, wait_cnt<=1, go to MEM_WAIT.
  - haz: op_stall=op_bubble=1. With PARAM_LOAD_LAT=1, stay in RUN. Otherwise lat_cnt<=PARAM_LOAD_LAT-1 and go to LOAD_STALL.
- LOAD_STALL:
  - op_stall=op_bubble=1 and lat_cnt decrements each cycle.
  - When lat_cnt==1, go to RUN.
  - branch_taken aborts the stall: op_flush=1, stall and bubble 0, go to RUN.
  - dmem_busy goes to MEM_WAIT with wait_cnt<=1.
- MEM_WAIT:
  - op_stall=op_freeze=1. ip_branch_taken is ignored because execute is frozen.
  - While busy, wait_cnt increments.
  - When busy drops, go to RUN; that cycle's outputs are RUN outputs.
  - If busy is still high when wait_cnt==PARAM_MEM_TIMEOUT: op_error<=1, go to RUN.
- Stall counter: increments by 1 on every cycle with op_stall=1 and holds at all-ones.
- op_error clears only on reset.

## Timing
- Outputs are Mealy: combinational from the registered state and the current inputs, with zero-cycle response to haz, branch and busy.
- A load-use hazard costs exactly PARAM_LOAD_LAT cycles of op_stall.
- A memory wait of N busy cycles, N < PARAM_MEM_TIMEOUT, costs N stall cycles.
- Reset asserted (low), asynchronously:
  - state=RUN, lat_cnt=0, wait_cnt=0, op_stall_count=0, op_error=0.
  - op_stall, op_bubble, op_freeze and op_flush are forced to 0 regardless of inputs.
  - op_state=2'b00.
- Reset deassertion: the first edge after release behaves as RUN.
- Reset asserted mid-stall aborts immediately; no residual stall after release.
- op_flush and op_stall are never both 1 in the same cycle.

## Test plan
- Load-use on rs: with mem_read=1, idex_rt=2, ifid_rs=2 and default params, expect exactly 1 cycle of stall=bubble=1, then RUN and op_stall_count=1. Repeat with idex_rt=0: no stall.
- LOAD_LAT=3 with a hazard on rt (uses_rt=1, ifid_rt=3=idex_rt): expect 3 cycles of stall and bubble and state sequence 00,01,01,00. Repeat with uses_rt=0: no stall.
- Branch abort: branch_taken in the 2nd LOAD_STALL cycle (LOAD_LAT=3) gives flush=1, stall=0 that cycle, and state=00 next.
- Memory wait: busy held for 4 cycles gives stall=freeze=1 for 4 cycles, then RUN, error=0 and count=4. Branch_taken during the wait produces no flush.
- Timeout: busy held for 20 cycles with TIMEOUT=15 sets error=1 after the 15th wait cycle and returns to RUN. Error stays 1 until reset is low.
- Counter saturation and reset: with CNT_WIDTH=4, 20 stall cycles leave count=15. Reset pulsed low mid-MEM_WAIT forces all outputs to 0 asynchronously.
